canny_frame_ctrl: RTL and testbench

Frame-level controller for the Canny edge pipeline. It sits beside the non-maximum-suppression stage and does four jobs: double-buffers the host-written hysteresis thresholds and applies them only at frame boundaries; sequences frames (enable / single-shot); masks the invalid 3x3-window border pixels; and checks line and frame geometry. Its outputs drive the downstream hysteresis/threshold stage.

---
 rtl/canny_frame_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_canny_frame_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_frame_ctrl.sv
// canny_frame_ctrl
//
// Frame-level controller for the Canny edge pipeline, placed beside the
// non-maximum-suppression stage. It double-buffers the hysteresis thresholds
// and applies them only at frame boundaries. It sequences frames in either
// continuous or single-shot mode, and masks the border pixels that have no
// valid 3x3 window. It also checks line length and line count against the
// configured image geometry.
//
// Ports
//   clk, rst_s            pipeline clock, asynchronous active-low reset
//   cfg_we/addr/wdata     host register write: 0 CTRL, 1 THR_LOW, 2 THR_HIGH
//   in_vsync/href/clken   pixel stream timing from the NMS stage
//   out_vsync/href/clken  stream timing delayed by one cycle
//   out_keep              pixel is interior and belongs to an accepted frame
//   thr_low, thr_high     thresholds in force for the current frame
//   frame_start/done      one-cycle pulses framing each accepted frame
//   line_err, frame_err   sticky geometry error flags
//   frame_cnt             number of completed accepted frames (wraps)

module canny_frame_ctrl #(
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int THR_WIDTH     = 10,
  parameter int THR_LOW_INIT  = 40,
  parameter int THR_HIGH_INIT = 100
) (
  input  logic                 clk,
  input  logic                 rst_s,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [15:0]          cfg_wdata,
  input  logic                 in_vsync,
  input  logic                 in_href,
  input  logic                 in_clken,
  output logic                 out_vsync,
  output logic                 out_href,
  output logic                 out_clken,
  output logic                 out_keep,
  output logic [THR_WIDTH-1:0] thr_low,
  output logic [THR_WIDTH-1:0] thr_high,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 line_err,
  output logic                 frame_err,
  output logic [15:0]          frame_cnt
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VS,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic                 ctrl_en;
  logic                 ctrl_ss;
  logic [THR_WIDTH-1:0] stg_low;
  logic [THR_WIDTH-1:0] stg_high;
  logic                 armed;
  logic [CW-1:0]        col_cnt;
  logic [RW-1:0]        row_cnt;

  logic                 ctrl_wr;
  logic                 low_wr;
  logic                 high_wr;
  logic                 err_clr;
  logic                 vs_fall;
  logic                 href_fall;
  logic                 go_active;
  logic                 in_active;
  logic                 keep_nxt;
  logic                 line_set;
  logic                 frame_set;
  logic                 unused_wdata;

  assign ctrl_wr = cfg_we && (cfg_addr == 2'd0);
  assign low_wr  = cfg_we && (cfg_addr == 2'd1);
  assign high_wr = cfg_we && (cfg_addr == 2'd2);
  assign err_clr = ctrl_wr && cfg_wdata[2];

  // The one-cycle delayed stream outputs double as the edge-detect history.
  assign vs_fall   = !in_vsync && out_vsync;
  assign href_fall = !in_href && out_href;

  assign unused_wdata = ^cfg_wdata;

  // State register
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Disabling during ACTIVE does not abort the frame.
  // Being armed means vsync was seen low while waiting, so vsync high now is
  // a true rising edge and a frame already in flight is never picked up.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (ctrl_en) state_nxt = S_WAIT_VS;
      S_WAIT_VS: begin
        if (!ctrl_en)                state_nxt = S_IDLE;
        else if (armed && in_vsync)  state_nxt = S_ACTIVE;
      end
      S_ACTIVE:  if (vs_fall) state_nxt = S_DONE;
      S_DONE:    state_nxt = (!ctrl_en || ctrl_ss) ? S_IDLE : S_WAIT_VS;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode. frame_done is simply the single DONE cycle, which falls
  // one cycle after the sampled vsync fall, aligned with out_vsync falling.
  always_comb begin
    go_active  = (state != S_ACTIVE) && (state != S_DONE) && (state_nxt == S_ACTIVE);
    in_active  = (state == S_ACTIVE);
    frame_done = (state == S_DONE);
    keep_nxt   = in_active && in_clken && in_href &&
                 (col_cnt >= CW'(1)) && (col_cnt <= CW'(IMG_WIDTH - 2)) &&
                 (row_cnt >= RW'(1)) && (row_cnt <= RW'(IMG_HEIGHT - 2));
    line_set   = in_active && href_fall && (col_cnt != CW'(IMG_WIDTH));
    frame_set  = frame_done && (row_cnt != RW'(IMG_HEIGHT));
  end

  // Stream delay and registered pixel mask
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      out_vsync <= 1'b0;
      out_href  <= 1'b0;
      out_clken <= 1'b0;
      out_keep  <= 1'b0;
    end else begin
      out_vsync <= in_vsync;
      out_href  <= in_href;
      out_clken <= in_clken;
      out_keep  <= keep_nxt;
    end
  end

  // Host registers. A CTRL write in the DONE cycle takes priority over the
  // single-shot auto-disable, so the host's latest intent is kept.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      ctrl_en  <= 1'b0;
      ctrl_ss  <= 1'b0;
      stg_low  <= THR_WIDTH'(THR_LOW_INIT);
      stg_high <= THR_WIDTH'(THR_HIGH_INIT);
    end else begin
      if (ctrl_wr) begin
        ctrl_en <= cfg_wdata[0];
        ctrl_ss <= cfg_wdata[1];
      end else if (frame_done && ctrl_ss) begin
        ctrl_en <= 1'b0;
      end
      if (low_wr)  stg_low  <= cfg_wdata[THR_WIDTH-1:0];
      if (high_wr) stg_high <= cfg_wdata[THR_WIDTH-1:0];
    end
  end

  // Active thresholds load from the staging copy only at frame start. A
  // staging write on that same edge is not seen here and lands next frame.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      thr_low     <= THR_WIDTH'(THR_LOW_INIT);
      thr_high    <= THR_WIDTH'(THR_HIGH_INIT);
      frame_start <= 1'b0;
    end else begin
      frame_start <= go_active;
      if (go_active) begin
        thr_low  <= stg_low;
        thr_high <= (stg_high < stg_low) ? stg_low : stg_high;
      end
    end
  end

  // Rising-edge arming. It clears whenever WAIT_VS is left or entered.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) armed <= 1'b0;
    else        armed <= (state == S_WAIT_VS) && (state_nxt == S_WAIT_VS) &&
                         (armed || !in_vsync);
  end

  // Pixel and line counters saturate at all-ones, so an over-long frame
  // still reads as wrong instead of wrapping back to a legal count.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (go_active) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_active) begin
      if (href_fall) begin
        col_cnt <= '0;
        if (row_cnt != '1) row_cnt <= row_cnt + RW'(1);
      end else if (in_href && in_clken && (col_cnt != '1)) begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  // Sticky errors: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      line_err  <= line_set  || (line_err  && !err_clr);
      frame_err <= frame_set || (frame_err && !err_clr);
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// tb_canny_frame_ctrl
//
// Directed bench for canny_frame_ctrl using a reduced 8x6 image so whole
// frames stay short. Interior pixels per frame: (8-2)*(6-2) = 24.

module tb_canny_frame_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int TW = 10;

  logic          clk = 1'b0;
  logic          rst_s = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [15:0]   cfg_wdata = '0;
  logic          in_vsync = 1'b0;
  logic          in_href = 1'b0;
  logic          in_clken = 1'b0;
  logic          out_vsync, out_href, out_clken, out_keep;
  logic [TW-1:0] thr_low, thr_high;
  logic          frame_start, frame_done, line_err, frame_err;
  logic [15:0]   frame_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  int            keep_cnt = 0;
  int            start_cnt = 0;
  int            done_cnt = 0;
  int            thr_moved = 0;
  int            align_err = 0;
  logic [TW-1:0] cap_low = 10'd40;
  logic [TW-1:0] cap_high = 10'd100;
  logic          prev_ov = 1'b0;

  int keep_base;
  int start_base;

  canny_frame_ctrl #(
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .THR_WIDTH    (TW),
    .THR_LOW_INIT (40),
    .THR_HIGH_INIT(100)
  ) dut (
    .clk        (clk),
    .rst_s      (rst_s),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .in_vsync   (in_vsync),
    .in_href    (in_href),
    .in_clken   (in_clken),
    .out_vsync  (out_vsync),
    .out_href   (out_href),
    .out_clken  (out_clken),
    .out_keep   (out_keep),
    .thr_low    (thr_low),
    .thr_high   (thr_high),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .line_err   (line_err),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // Output monitor on the falling edge: counts kept pixels and pulses,
  // captures thresholds at frame start, and flags any threshold change or
  // pulse misaligned with out_vsync edges.
  always @(negedge clk) begin
    if (!rst_s) begin
      cap_low  <= 10'd40;
      cap_high <= 10'd100;
      prev_ov  <= 1'b0;
    end else begin
      if (out_keep) keep_cnt <= keep_cnt + 1;
      if (frame_start) begin
        start_cnt <= start_cnt + 1;
        cap_low   <= thr_low;
        cap_high  <= thr_high;
        if (!(out_vsync && !prev_ov)) align_err <= align_err + 1;
      end else if (thr_low != cap_low || thr_high != cap_high) begin
        thr_moved <= thr_moved + 1;
      end
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        if (!(!out_vsync && prev_ov)) align_err <= align_err + 1;
      end
      prev_ov <= out_vsync;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic h, input logic c);
    in_vsync = v;
    in_href  = h;
    in_clken = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // One frame; the first vsync cycle may carry a register write so it
  // coincides with the sampled vsync rise.
  task automatic send_frame(input int lines, input int short_line, input int short_len,
                            input logic co_we, input logic [1:0] co_addr,
                            input logic [15:0] co_data);
    cfg_we    = co_we;
    cfg_addr  = co_addr;
    cfg_wdata = co_data;
    cycle(1'b1, 1'b0, 1'b0);
    cfg_we = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ((l == short_line) ? short_len : W); p++)
        cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
    end
    idle(4);
  endtask

  task automatic frame(input int lines);
    send_frame(lines, -1, 0, 1'b0, 2'd0, 16'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_vsync", 32'(out_vsync), 0);
    check("rst_out_keep", 32'(out_keep), 0);
    check("rst_thr_low", 32'(thr_low), 40);
    check("rst_thr_high", 32'(thr_high), 100);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_errs", {30'd0, line_err, frame_err}, 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    rst_s = 1'b1;
    idle(2);

    // Pass-through while disabled
    cycle(1'b1, 1'b0, 1'b0);
    check("pt_vsync_hi", 32'(out_vsync), 1);
    check("pt_href_lo", 32'(out_href), 0);
    cycle(1'b1, 1'b1, 1'b1);
    check("pt_href_hi", 32'(out_href), 1);
    check("pt_clken_hi", 32'(out_clken), 1);
    check("pt_keep_off", 32'(out_keep), 0);
    cycle(1'b0, 1'b0, 1'b0);
    check("pt_vsync_lo", 32'(out_vsync), 0);
    check("pt_no_start", 32'(start_cnt), 0);

    // Nominal: thresholds staged mid frame 1 apply to frame 2
    cfg_write(2'd0, 16'h0001);
    idle(4);
    keep_base = keep_cnt;
    fork
      frame(H);
      begin
        repeat (20) @(posedge clk);
        #1;
        cfg_write(2'd1, 16'd20);
        cfg_write(2'd2, 16'd60);
      end
    join
    check("f1_thr_low", 32'(cap_low), 40);
    check("f1_thr_high", 32'(cap_high), 100);
    check("f1_keep", 32'(keep_cnt - keep_base), 24);
    check("f1_cnt", 32'(frame_cnt), 1);
    keep_base = keep_cnt;
    frame(H);
    check("f2_thr_low", 32'(cap_low), 20);
    check("f2_thr_high", 32'(cap_high), 60);
    check("f2_keep", 32'(keep_cnt - keep_base), 24);
    check("f2_cnt", 32'(frame_cnt), 2);
    check("f2_line_err", 32'(line_err), 0);
    check("f2_frame_err", 32'(frame_err), 0);
    check("f2_starts", 32'(start_cnt), 2);
    check("f2_dones", 32'(done_cnt), 2);

    // Short line sets a sticky line error; CTRL=0x5 clears, keeps enable
    send_frame(H, 2, 7, 1'b0, 2'd0, 16'd0);
    check("short_line_err", 32'(line_err), 1);
    check("short_frame_err", 32'(frame_err), 0);
    frame(H);
    check("sticky_line_err", 32'(line_err), 1);
    check("sticky_cnt", 32'(frame_cnt), 4);
    cfg_write(2'd0, 16'h0005);
    idle(1);
    check("clr_line_err", 32'(line_err), 0);
    frame(H);
    check("clr_enable_kept", 32'(start_cnt), 5);
    check("clr_cnt", 32'(frame_cnt), 5);

    // Late enable: frame already in flight is skipped
    cfg_write(2'd0, 16'h0000);
    idle(3);
    keep_base = keep_cnt;
    start_base = start_cnt;
    fork
      frame(H);
      begin
        repeat (4) @(posedge clk);
        #1;
        cfg_write(2'd0, 16'h0001);
      end
    join
    check("late_no_start", 32'(start_cnt - start_base), 0);
    check("late_no_keep", 32'(keep_cnt - keep_base), 0);
    frame(H);
    check("late_next_start", 32'(start_cnt - start_base), 1);
    check("late_cnt", 32'(frame_cnt), 6);

    // Single-shot: three frames offered, one accepted
    cfg_write(2'd0, 16'h0003);
    idle(2);
    start_base = start_cnt;
    frame(H);
    frame(H);
    frame(H);
    check("ss_starts", 32'(start_cnt - start_base), 1);
    check("ss_dones", 32'(done_cnt), 7);
    check("ss_cnt", 32'(frame_cnt), 7);

    // Inverted thresholds, plus a write coincident with frame start
    cfg_write(2'd1, 16'd90);
    cfg_write(2'd2, 16'd30);
    cfg_write(2'd0, 16'h0001);
    idle(4);
    send_frame(H, -1, 0, 1'b1, 2'd1, 16'd5);
    check("inv_thr_low", 32'(cap_low), 90);
    check("inv_thr_high", 32'(cap_high), 90);
    frame(H);
    check("co_thr_low", 32'(cap_low), 5);
    check("co_thr_high", 32'(cap_high), 30);
    check("co_cnt", 32'(frame_cnt), 9);
    check("thr_stable", 32'(thr_moved), 0);

    // Reset in mid frame, then an over-long frame
    fork
      frame(H);
      begin
        repeat (2 + 2 * (W + 2) + 3) @(posedge clk);
        #1;
        rst_s = 1'b0;
        @(negedge clk);
        check("mr_out_vsync", 32'(out_vsync), 0);
        check("mr_out_keep", 32'(out_keep), 0);
        check("mr_thr_low", 32'(thr_low), 40);
        check("mr_thr_high", 32'(thr_high), 100);
        check("mr_frame_cnt", 32'(frame_cnt), 0);
        @(posedge clk);
        #1;
        rst_s = 1'b1;
      end
    join
    cfg_write(2'd0, 16'h0001);
    idle(4);
    frame(H + 1);
    check("long_frame_err", 32'(frame_err), 1);
    check("long_line_err", 32'(line_err), 0);
    check("long_cnt", 32'(frame_cnt), 1);
    check("long_thr_low", 32'(cap_low), 40);
    check("pulse_align", 32'(align_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
